// File: rtl/sec_count60.sv
// -----------------------------------------------------------------------------
// sec_count60
//
// Seconds counter feeding the binary-to-BCD / 7-segment display stage.
// A prescaler derives a count tick every DIV cycles of the 50 MHz board clock.
// The count runs 0..59 and wraps. Two push-buttons start/stop the count and
// clear it. Each button is synchronised, debounced and reduced to a
// one-cycle press event.
//
// Parameters:
//   DIV        clock cycles per count tick (>= 10, so x is stable for a full
//              downstream conversion window)
//   DB_CYCLES  consecutive stable cycles before a button level is accepted
//              (>= 1)
//
// Ports:
//   clk_50mHz  in   1  single clock; all state changes on its rising edge
//   rst_n      in   1  asynchronous assert, active-low reset
//   btn_run    in   1  asynchronous push-button; each press toggles run/stop
//   btn_clr    in   1  asynchronous push-button; each press clears the count
//   x          out  8  registered binary count 0..59 (bits [7:6] always 0)
//   carry      out  1  registered one-cycle pulse on the 59 -> 0 wrap
//   running    out  1  high while the FSM is in RUN (this is the FSM state)
//
// Build option:
//   SEC_COUNT60_DEBOUNCE_EN  defined   : debouncer requires DB_CYCLES stable
//                                        cycles before accepting a level
//                            undefined : debouncer removed; db follows the
//                                        synchroniser output through a single
//                                        register and DB_CYCLES is ignored
//
// Handshake: there is no valid/ready traffic in this block. A press event is a
// single-cycle strobe (db & ~db_q) that is consumed unconditionally on the
// next rising edge; there is no back-pressure.
// -----------------------------------------------------------------------------
module sec_count60 #(
   parameter int DIV       = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk_50mHz,
   input  logic       rst_n,
   input  logic       btn_run,
   input  logic       btn_clr,
   output logic [7:0] x,
   output logic       carry,
   output logic       running
);

   // Elaboration-time guards on the legal parameter range.
   if (DIV < 10) begin : g_bad_div
      $error("sec_count60: DIV must be 10 or more");
   end
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("sec_count60: DB_CYCLES must be 1 or more");
   end

   // --------------------------------------------------------------------------
   // Local constants
   // --------------------------------------------------------------------------
   localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
   localparam logic [7:0]     X_LAST   = 8'd59;

   // Button channel index inside the packed button vectors.
   localparam int B_RUN = 0;
   localparam int B_CLR = 1;

   // --------------------------------------------------------------------------
   // FSM state
   // --------------------------------------------------------------------------
   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   // --------------------------------------------------------------------------
   // Button path: 2-flop synchroniser -> debouncer (db) -> edge register
   // --------------------------------------------------------------------------
   logic [1:0] btn_raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] db;
   logic [1:0] db_q;
   logic [1:0] press;
   logic       run_ev;
   logic       clr_ev;

   assign btn_raw = {btn_clr, btn_run};

   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

`ifdef SEC_COUNT60_DEBOUNCE_EN
   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   // db_cnt counts how many consecutive cycles the synchronised level has
   // disagreed with db. When that run reaches DB_CYCLES the new level is
   // taken; any cycle of agreement (a bounce back) restarts the run.
   logic [CW-1:0] db_cnt [2];

   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db[i]) begin
               if (db_cnt[i] == CNT_LAST) begin
                  db[i]     <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end
`else
   // Without debouncing db is simply a registered copy of the synchroniser,
   // which behaves exactly like a one-cycle acceptance window: every
   // synchronised rising edge, bounce included, becomes a press event.
   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
      end else begin
         db <= sync2;
      end
   end
`endif

   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         db_q <= '0;
      end else begin
         db_q <= db;
      end
   end

   // Rising edge of the accepted level only; releases produce no event.
   assign press  = db & ~db_q;
   assign run_ev = press[B_RUN];
   assign clr_ev = press[B_CLR];

   // --------------------------------------------------------------------------
   // Run/stop FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_STOP;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOP: if (run_ev) state_nxt = ST_RUN;
         ST_RUN:  if (run_ev) state_nxt = ST_STOP;
         default: state_nxt = ST_STOP;
      endcase
   end

   assign running = (state == ST_RUN);

   // --------------------------------------------------------------------------
   // Prescaler and 0..59 counter
   // --------------------------------------------------------------------------
   logic [PW-1:0] pre;
   logic [PW-1:0] pre_nxt;
   logic [7:0]    x_nxt;
   logic          carry_nxt;
   logic          tick;

   assign tick = running && (pre == PRE_LAST);

   always_comb begin
      pre_nxt   = '0;
      x_nxt     = x;
      carry_nxt = 1'b0;

      if (clr_ev) begin
         // Clear wins over a coincident tick: no increment, no carry, and the
         // prescaler restarts so the next tick is a full DIV cycles away.
         pre_nxt   = '0;
         x_nxt     = '0;
         carry_nxt = 1'b0;
      end else begin
         if (running) begin
            pre_nxt = (pre == PRE_LAST) ? '0 : pre + 1'b1;
         end
         if (tick) begin
            // ">=" also recovers an out-of-range count to 0; only a true
            // 59 -> 0 step raises carry.
            if (x >= X_LAST) begin
               x_nxt = '0;
            end else begin
               x_nxt = x + 8'd1;
            end
            carry_nxt = (x == X_LAST);
         end
      end
   end

   always_ff @(posedge clk_50mHz or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         x     <= '0;
         carry <= 1'b0;
      end else begin
         pre   <= pre_nxt;
         x     <= x_nxt;
         carry <= carry_nxt;
      end
   end

endmodule

// File: tb/tb_sec_count60.sv
// -----------------------------------------------------------------------------
// tb_sec_count60
//
// Bench for sec_count60 with DIV=10 and DB_CYCLES=4. A behavioural model that
// works from the button sample history and count/phase arithmetic predicts
// x, carry and running every cycle; directed sequences cover latency, wrap,
// clear-vs-tick priority and asynchronous reset, followed by random presses.
// Works with SEC_COUNT60_DEBOUNCE_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_sec_count60;

   localparam int DIV = 10;
   localparam int DBC = 4;

`ifdef SEC_COUNT60_DEBOUNCE_EN
   localparam int ACCEPT       = DBC;
   localparam int SHORT_RUN    = 1;   // running after a 3-cycle pulse (ignored)
   localparam int BOUNCE_RUN   = 0;   // after bounce: one toggle from 1
`else
   localparam int ACCEPT       = 1;
   localparam int SHORT_RUN    = 0;   // 3-cycle pulse is a toggle from 1
   localparam int BOUNCE_RUN   = 1;   // three synchronised edges from 0
`endif
   // Rising edges from the first edge that samples a press to the edge that
   // updates running: 2 synchroniser + acceptance + 1 edge register.
   localparam int LAT = 2 + ACCEPT + 1;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_run = 1'b0;
   logic       btn_clr = 1'b0;
   logic [7:0] x;
   logic       carry;
   logic       running;

   always #10 clk = ~clk;

   sec_count60 #(.DIV(DIV), .DB_CYCLES(DBC)) dut (
      .clk_50mHz (clk),
      .rst_n     (rst_n),
      .btn_run   (btn_run),
      .btn_clr   (btn_clr),
      .x         (x),
      .carry     (carry),
      .running   (running)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard counters and checking task
   // ---------------------------------------------------------------------------
   int vectors     = 0;
   int miscompares = 0;
   int carry_seen  = 0;
   bit chk_on      = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   bit [1:0] m_s1, m_s2, m_db, m_dbq;   // bit 0 = run, bit 1 = clr
   bit [1:0] hist[$];                   // last ACCEPT synchronised samples
   bit       m_run;
   int       m_phase;                   // cycles into the current second
   int       m_x;
   bit       m_carry;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0;
      hist.delete();
      m_run = 1'b0; m_phase = 0; m_x = 0; m_carry = 1'b0;
   endtask

   task automatic model_step();
      bit       ev_run, ev_clr, tick, flip;
      bit [1:0] new_db;
      ev_run = m_db[0] & ~m_dbq[0];
      ev_clr = m_db[1] & ~m_dbq[1];
      tick   = m_run && (m_phase == DIV - 1);

      if (ev_clr) begin
         m_x = 0; m_carry = 1'b0; m_phase = 0;
      end else begin
         m_carry = tick && (m_x == 59);
         if (tick) m_x = (m_x >= 59) ? 0 : m_x + 1;
         m_phase = m_run ? (m_phase + 1) % DIV : 0;
      end
      if (ev_run) m_run = !m_run;

      // A level is accepted once the last ACCEPT samples all disagree with it.
      hist.push_back(m_s2);
      if (hist.size() > ACCEPT) void'(hist.pop_front());
      new_db = m_db;
      if (hist.size() == ACCEPT) begin
         for (int i = 0; i < 2; i++) begin
            flip = 1'b1;
            foreach (hist[j]) if (hist[j][i] == m_db[i]) flip = 1'b0;
            if (flip) new_db[i] = ~m_db[i];
         end
      end
      m_dbq = m_db;
      m_db  = new_db;
      m_s2  = m_s1;
      m_s1  = {btn_clr, btn_run};
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("x", x, m_x);
         check("carry", carry, m_carry);
         check("running", running, m_run);
         if (carry) carry_seen++;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_run(input int len);
      btn_run = 1'b1; cycles(len); btn_run = 1'b0;
   endtask

   // Wait (bounded) until the model reaches a count/phase; phase < 0 = any.
   task automatic wait_model(input int xv, input int ph, input string tag);
      int n;
      n = 0;
      while (!(m_x == xv && (ph < 0 || m_phase == ph)) && n < 2000) begin
         @(negedge clk); n++;
      end
      check(tag, (n < 2000) ? 1 : 0, 1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin : stim
      int det;
      model_reset();
      chk_on = 1'b1;
      cycles(3);
      rst_n = 1'b1;

      // 1. Idle after reset.
      cycles(100);
      check("idle_x", x, 0);
      check("idle_running", running, 0);

      // 2. One held press -> running after LAT cycles, then a full minute.
      btn_run = 1'b1;
      det = 0;
      carry_seen = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (running && det == 0) det = i;
      end
      btn_run = 1'b0;
      check("run_latency", det, LAT);
      cycles(600 - (8 - det));
      cycles(1);
      check("minute_x", x, 0);
      check("minute_carry_pulses", carry_seen, 1);

      // 3. Short pulse, then bounce 1,0,1,0 followed by a hold.
      press_run(3);
      cycles(20);
      check("short_pulse", running, SHORT_RUN);
      btn_run = 1'b1; cycles(1); btn_run = 1'b0; cycles(1);
      btn_run = 1'b1; cycles(1); btn_run = 1'b0; cycles(1);
      press_run(8);
      cycles(20);
      check("bounce", running, BOUNCE_RUN);

      // 4. Clear lands on the 59 -> 0 tick.
      if (!m_run) begin
         press_run(8);
         cycles(LAT + 2);
      end
      check("pre_clr_running", running, 1);
      wait_model(59, (DIV - LAT) % DIV, "wait_59");
      btn_clr = 1'b1;
      carry_seen = 0;
      for (int i = 1; i <= LAT + 10; i++) begin
         @(negedge clk);
         if (i == 8) btn_clr = 1'b0;
         if (i == LAT) begin
            check("clr_tick_x", x, 0);
            check("clr_tick_carry", carry, 0);
            check("clr_tick_running", running, 1);
         end
         if (i == LAT + 9)  check("clr_hold_x", x, 0);
         if (i == LAT + 10) check("clr_next_x", x, 1);
      end
      check("clr_no_carry", carry_seen, 0);

      // 5. Asynchronous reset mid-count, then stay stopped.
      wait_model(23, -1, "wait_23");
      @(posedge clk);
      #5 rst_n = 1'b0;
      #1;
      check("arst_x", x, 0);
      check("arst_carry", carry, 0);
      check("arst_running", running, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(50);
      check("post_reset_stop", running, 0);

      // Button held across reset release gives exactly one press.
      btn_run = 1'b1;
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(10);
      btn_run = 1'b0;
      cycles(20);
      check("held_through_reset", running, 1);

      // 6. Random presses on both buttons.
      for (int k = 0; k < 300; k++) begin
         btn_run = ($urandom_range(0, 3) == 0);
         btn_clr = ($urandom_range(0, 5) == 0);
         cycles($urandom_range(1, 8));
      end
      btn_run = 1'b0;
      btn_clr = 1'b0;
      cycles(20);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
